serial_frame_responder: RTL

- Far end of the dumbserial two-wire link (source-synchronous serial clock + data, 16-bit frames, MSB first).
- Receives a frame on its own local clock domain, presents the word, then automatically transmits a reply frame (received word XOR REPLY_XOR) back on a return link it clocks itself.
- Used as link partner and loopback responder for the existing frame sender/receiver pair.

---
 rtl/serial_frame_responder_if.sv | 55 +++++
 rtl/serial_frame_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_responder_if
// Description : Bundle of the serial link pins and the received-word status
//               of serial_frame_responder.
//               slave  - the responder side (drives word/status/reply pins)
//               master - the link partner / system side
// Signals     : serialClockIn, serialDataIn  incoming serial link
//               clearOverrun                 clears the sticky overrun flag
//               receiveData, receiveValid    last received word + update pulse
//               framingError                 partial frame discarded pulse
//               overrun                      sticky: frame arrived while busy
//               serialClockOut, serialDataOut reply serial link
//               replyBusy                    reply transmitter not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_frame_responder_if;
    logic        serialClockIn;
    logic        serialDataIn;
    logic        clearOverrun;
    logic [15:0] receiveData;
    logic        receiveValid;
    logic        framingError;
    logic        overrun;
    logic        serialClockOut;
    logic        serialDataOut;
    logic        replyBusy;

    modport slave (
        input  serialClockIn,
        input  serialDataIn,
        input  clearOverrun,
        output receiveData,
        output receiveValid,
        output framingError,
        output overrun,
        output serialClockOut,
        output serialDataOut,
        output replyBusy
    );

    modport master (
        output serialClockIn,
        output serialDataIn,
        output clearOverrun,
        input  receiveData,
        input  receiveValid,
        input  framingError,
        input  overrun,
        input  serialClockOut,
        input  serialDataOut,
        input  replyBusy
    );
endinterface
`default_nettype wire

// File: rtl/serial_frame_responder.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_responder
// Description : Far end of the two-wire serial link. Receives 16-bit MSB-first
//               frames on an asynchronous serial clock, presents the word and
//               answers with (word ^ REPLY_XOR) on a self-clocked return link.
// Ports       : clock   - local clock, all logic on its rising edge
//               resetN  - synchronous reset, active-low
//               bus     - serial_frame_responder_if.slave (link pins + status)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_responder #(
    parameter int          CLK_DIV      = 4,
    parameter int          GAP_CYCLES   = 32,
    parameter int          IDLE_TIMEOUT = 64,
    parameter logic [15:0] REPLY_XOR    = 16'hFFFF
) (
    input  wire logic                 clock,
    input  wire logic                 resetN,
    serial_frame_responder_if.slave   bus
);

    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    // Receive side
    logic [2:0]        sclk_sync_q, sclk_sync_d;
    logic [1:0]        sdat_sync_q, sdat_sync_d;
    logic [3:0]        bit_cnt_q,   bit_cnt_d;
    logic [14:0]       shift_q,     shift_d;
    logic [IDLE_W-1:0] idle_cnt_q,  idle_cnt_d;
    logic [15:0]       rx_data_q,   rx_data_d;
    logic              rx_valid_q,  rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q,   overrun_d;
    // Reply transmitter
    logic [1:0]        state_q,     state_d;
    logic [CNT_W-1:0]  cyc_q,       cyc_d;
    logic [3:0]        bit_idx_q,   bit_idx_d;
    logic [15:0]       reply_q,     reply_d;

    logic              edge_w;
    logic              bit_w;

    // Clock and data share the same synchroniser depth, so the data bit seen
    // alongside the detected edge is the one present at the pin edge.
    assign edge_w = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign bit_w  = sdat_sync_q[1];

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], bus.serialClockIn};
        sdat_sync_d = {sdat_sync_q[0], bus.serialDataIn};
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        idle_cnt_d  = idle_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;
        state_d     = state_q;
        cyc_d       = cyc_q;
        bit_idx_d   = bit_idx_q;
        reply_d     = reply_q;

        if (edge_w) begin
            idle_cnt_d = '0;
            if (bit_cnt_q == 4'd15) begin
                rx_data_d  = {shift_q, bit_w};
                rx_valid_d = 1'b1;
                bit_cnt_d  = 4'd0;
            end else begin
                shift_d   = {shift_q[13:0], bit_w};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
            // Fires only on the cycle the counter reaches the limit; an empty
            // frame counter means there is nothing to discard.
            if ((idle_cnt_q == IDLE_LAST) && (bit_cnt_q != 4'd0)) begin
                bit_cnt_d   = 4'd0;
                frame_err_d = 1'b1;
            end
        end

        // Setting has priority over clearing in the same cycle.
        if (rx_valid_q && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else if (bus.clearOverrun) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_valid_q) begin
                    reply_d   = rx_data_q ^ REPLY_XOR;
                    bit_idx_d = 4'd15;
                    cyc_d     = '0;
                    state_d   = S_LOW;
                end
            end
            S_LOW: begin
                if (cyc_q == DIV_LAST) begin
                    cyc_d   = '0;
                    state_d = S_HIGH;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (cyc_q == DIV_LAST) begin
                    cyc_d = '0;
                    if (bit_idx_q != 4'd0) begin
                        bit_idx_d = bit_idx_q - 4'd1;
                        state_d   = S_LOW;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: begin
                if (cyc_q == GAP_LAST) begin
                    cyc_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            sclk_sync_q <= '0;
            sdat_sync_q <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            idle_cnt_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            bit_idx_q   <= '0;
            reply_q     <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            sdat_sync_q <= sdat_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            idle_cnt_q  <= idle_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            bit_idx_q   <= bit_idx_d;
            reply_q     <= reply_d;
        end
    end

    assign bus.receiveData    = rx_data_q;
    assign bus.receiveValid   = rx_valid_q;
    assign bus.framingError   = frame_err_q;
    assign bus.overrun        = overrun_q;
    assign bus.replyBusy      = (state_q != S_IDLE);
    assign bus.serialClockOut = (state_q == S_HIGH);
    // Bit index only moves on entry to LOW, so data is stable while clock high.
    assign bus.serialDataOut  = ((state_q == S_LOW) || (state_q == S_HIGH)) ? reply_q[bit_idx_q] : 1'b0;

endmodule
`default_nettype wire
